uart_frame_ctrl: RTL and testbench

- Command-frame controller behind the UART byte receiver. Consumes received bytes and sequences them through a 4-byte frame parser: header, address, data, checksum.
- Frames that pass the checksum write a small register file; register 0 drives the board LEDs.
- Reports per-frame OK/error pulses and a saturating error count.

---
 rtl/uart_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// Command-frame controller: parses header/addr/data/checksum byte frames and writes a two-entry register file.
// Optional inter-byte timeout is compiled in with `define FRAME_TIMEOUT_EN.
module uart_frame_ctrl #(
   parameter logic [7:0] HDR  = 8'h55,
   parameter int         TOUT = 104160
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_vld,
   output logic [7:0] led,
   output logic [7:0] aux_reg,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [7:0] err_cnt
);

   // state  | meaning
   // IDLE   | hunting for the header byte; other bytes are dropped silently
   // S_ADDR | header seen, next byte is the register address
   // S_DATA | address latched, next byte is the write data
   // S_CHK  | data latched, next byte is the checksum (addr + data mod 256)
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_CHK  = 2'd3
   } state_t;

   localparam logic [7:0] ADDR_LED = 8'h00;
   localparam logic [7:0] ADDR_AUX = 8'h01;

   state_t     state_q, state_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic [7:0] sum_q, sum_d;
   logic [7:0] led_q, led_d;
   logic [7:0] aux_q, aux_d;
   logic       ok_q, ok_d;
   logic       err_q, err_d;
   logic [7:0] err_cnt_q, err_cnt_d;

`ifdef FRAME_TIMEOUT_EN
   localparam logic [16:0] TOUT_LAST = 17'(TOUT - 1);

   logic [16:0] tout_q, tout_d;
   logic        tout_hit;

   // A byte arriving on the terminal-count cycle takes precedence over the timeout.
   assign tout_hit = (state_q != IDLE) && !rx_vld && (tout_q == TOUT_LAST);

   always_comb begin
      tout_d = tout_q + 17'd1;
      if (state_q == IDLE || rx_vld || tout_hit) begin
         tout_d = 17'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tout_q <= 17'd0;
      end else begin
         tout_q <= tout_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      sum_d   = sum_q;
      led_d   = led_q;
      aux_d   = aux_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rx_vld && rx_data == HDR) begin
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (rx_vld) begin
               addr_d  = rx_data;
               sum_d   = rx_data;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rx_vld) begin
               data_d  = rx_data;
               sum_d   = sum_q + rx_data;
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_vld) begin
               state_d = IDLE;
               if (rx_data != sum_q) begin
                  err_d = 1'b1;
               end else if (addr_q == ADDR_LED) begin
                  led_d = data_q;
                  ok_d  = 1'b1;
               end else if (addr_q == ADDR_AUX) begin
                  aux_d = data_q;
                  ok_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef FRAME_TIMEOUT_EN
      if (tout_hit) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
`endif
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && err_cnt_q != 8'hff) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= 8'h00;
         data_q    <= 8'h00;
         sum_q     <= 8'h00;
         led_q     <= 8'hff;
         aux_q     <= 8'h00;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         sum_q     <= sum_d;
         led_q     <= led_d;
         aux_q     <= aux_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign led       = led_q;
   assign aux_reg   = aux_q;
   assign frame_ok  = ok_q;
   assign frame_err = err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl; the timeout section follows FRAME_TIMEOUT_EN with a shortened TOUT.
module tb_uart_frame_ctrl;

   localparam int TB_TOUT = 50;

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_vld;
   logic [7:0] led;
   logic [7:0] aux_reg;
   logic       frame_ok;
   logic       frame_err;
   logic [7:0] err_cnt;

   int n_total = 0;
   int n_fail  = 0;

   uart_frame_ctrl #(.TOUT(TB_TOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_vld    (rx_vld),
      .led       (led),
      .aux_reg   (aux_reg),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Byte is presented for one posedge; returns at the following negedge, when registered results are visible.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_vld  = 1'b1;
      @(negedge clk);
      rx_vld  = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
      send_byte(8'h55);
      send_byte(a);
      send_byte(d);
      send_byte(c);
   endtask

   initial begin
      rst_n   = 1'b0;
      rx_data = 8'h00;
      rx_vld  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_led", led, 8'hff);
      chk("rst_aux", aux_reg, 8'h00);
      chk("rst_ok", frame_ok, 1'b0);
      chk("rst_err", frame_err, 1'b0);
      chk("rst_errcnt", err_cnt, 8'h00);
      rst_n = 1'b1;

      // Good write to LED register
      send_frame(8'h00, 8'ha5, 8'ha5);
      chk("t1_ok", frame_ok, 1'b1);
      chk("t1_err", frame_err, 1'b0);
      chk("t1_led", led, 8'ha5);
      chk("t1_errcnt", err_cnt, 8'h00);
      @(negedge clk);
      chk("t1_ok_width", frame_ok, 1'b0);

      // Good write to aux register
      send_frame(8'h01, 8'h3c, 8'h3d);
      chk("t2_ok", frame_ok, 1'b1);
      chk("t2_aux", aux_reg, 8'h3c);
      chk("t2_led", led, 8'ha5);

      // Bad checksum
      send_frame(8'h00, 8'h12, 8'h13);
      chk("t3_err", frame_err, 1'b1);
      chk("t3_ok", frame_ok, 1'b0);
      chk("t3_led", led, 8'ha5);
      chk("t3_errcnt", err_cnt, 8'h01);
      @(negedge clk);
      chk("t3_err_width", frame_err, 1'b0);

      // Leading junk ignored, then unknown address 0x02 with valid checksum
      send_byte(8'h00);
      send_byte(8'hff);
      chk("t4_junk_err", frame_err, 1'b0);
      send_frame(8'h02, 8'h10, 8'h12);
      chk("t4_err", frame_err, 1'b1);
      chk("t4_ok", frame_ok, 1'b0);
      chk("t4_errcnt", err_cnt, 8'h02);
      chk("t4_led", led, 8'ha5);
      chk("t4_aux", aux_reg, 8'h3c);

      // Header value inside a frame is payload, not a resync
      send_frame(8'h00, 8'h55, 8'h55);
      chk("t5_ok", frame_ok, 1'b1);
      chk("t5_led", led, 8'h55);

      // Strobe held high for four consecutive cycles counts as four bytes
      @(negedge clk);
      rx_data = 8'h55; rx_vld = 1'b1;
      @(negedge clk); rx_data = 8'h01;
      @(negedge clk); rx_data = 8'h22;
      @(negedge clk); rx_data = 8'h23;
      @(negedge clk); rx_vld = 1'b0;
      chk("t6_ok", frame_ok, 1'b1);
      chk("t6_aux", aux_reg, 8'h22);

      // Partial frame followed by silence
      send_byte(8'h55);
      send_byte(8'h00);
`ifdef FRAME_TIMEOUT_EN
      repeat (TB_TOUT - 1) @(negedge clk);
      chk("t7_pre_tout_err", frame_err, 1'b0);
      @(negedge clk);
      chk("t7_tout_err", frame_err, 1'b1);
      chk("t7_tout_errcnt", err_cnt, 8'h03);
      send_frame(8'h00, 8'h77, 8'h77);
`else
      repeat (300) @(negedge clk);
      chk("t7_no_tout_err", frame_err, 1'b0);
      chk("t7_no_tout_errcnt", err_cnt, 8'h02);
      send_byte(8'h77);
      send_byte(8'h77);
`endif
      chk("t7_ok", frame_ok, 1'b1);
      chk("t7_led", led, 8'h77);

      // Reset in the middle of a frame
      send_byte(8'h55);
      send_byte(8'h01);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t8_rst_led", led, 8'hff);
      chk("t8_rst_aux", aux_reg, 8'h00);
      chk("t8_rst_errcnt", err_cnt, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(8'h01, 8'h09, 8'h0a);
      chk("t8_ok", frame_ok, 1'b1);
      chk("t8_aux", aux_reg, 8'h09);

      // Error counter saturation
      repeat (254) send_frame(8'h00, 8'h12, 8'h13);
      chk("t9_errcnt_254", err_cnt, 8'hfe);
      send_frame(8'h00, 8'h12, 8'h13);
      chk("t9_errcnt_255", err_cnt, 8'hff);
      repeat (5) send_frame(8'h00, 8'h12, 8'h13);
      chk("t9_sat_err", frame_err, 1'b1);
      chk("t9_sat_errcnt", err_cnt, 8'hff);
      chk("t9_sat_led", led, 8'hff);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
